// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU data-memory bus between the CPU data port and mem_responder
interface mem_responder_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_busy;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_busy, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_busy, mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM plus MMIO responder with busy/ready handshake and wait states
module mem_responder #(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic [7:0]      leds
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] addr_q, wdata_q;
    logic        wr_q;
    logic [3:0]  cnt;
    logic [15:0] cycle_cnt;
    logic        err;
    logic [15:0] rdata_q;
    logic        busy_q, ready_q;
    logic        start, commit;
    logic        is_mmio;
    logic [15:0] read_val;

    logic [15:0] ram [0:(1<<ADDR_W)-1];

    assign is_mmio       = (addr_q >= MMIO_BASE);
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_ready = ready_q;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_rd || bus.mem_wr) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_val = 16'h0000;
        if (!is_mmio)
            read_val = ram[addr_q[ADDR_W-1:0]];
        else if (addr_q == MMIO_BASE)
            read_val = {8'h00, leds};
        else if (addr_q == MMIO_BASE + 16'd1)
            read_val = cycle_cnt;
        else if (addr_q == MMIO_BASE + 16'd2)
            read_val = {14'b0, err, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            wr_q      <= 1'b0;
            cnt       <= 4'd0;
            cycle_cnt <= 16'h0000;
            err       <= 1'b0;
            rdata_q   <= 16'h0000;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            leds      <= 8'h00;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            busy_q    <= (state_next == ACCESS);
            ready_q   <= (state_next == DONE);
            if (start) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                wr_q    <= bus.mem_wr;
                cnt     <= 4'(WAIT_STATES);
                // Conflicting strobes resolve to a write but are remembered as an error
                if (bus.mem_rd && bus.mem_wr) err <= 1'b1;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (!wr_q)
                    rdata_q <= read_val;
                else if (addr_q == MMIO_BASE)
                    leds <= wdata_q[7:0];
            end
        end
    end

    // RAM has no reset; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q && !is_mmio)
            ram[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a behavioural model
module tb_mem_responder;
    localparam int WS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] leds;

    mem_responder_if bus();

    mem_responder #(.ADDR_W(12), .WAIT_STATES(WS), .MMIO_BASE(16'hFF00)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .leds (leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Cycles elapsed since the last reset edge, i.e. the value the counter register holds now
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [15:0] mram [int];
    logic [7:0]  m_leds;
    logic        m_err;
    logic [15:0] m_rdata;
    bit          m_rdata_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_read(input logic [15:0] a, input int unsigned c,
                                       output logic [15:0] v, output bit known);
        known = 1'b1;
        v     = 16'h0000;
        if (a >= 16'hFF00) begin
            case (a)
                16'hFF00: v = {8'h00, m_leds};
                16'hFF01: v = 16'(c + 1 + WS);
                16'hFF02: v = {14'b0, m_err, 1'b1};
                default:  v = 16'h0000;
            endcase
        end else if (mram.exists(int'(a[11:0]))) begin
            v = mram[int'(a[11:0])];
        end else begin
            known = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_leds        = 8'h00;
        m_err         = 1'b0;
        m_rdata       = 16'h0000;
        m_rdata_known = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] exp;
        bit          known;
        int          busy_n;
        int          ready_at;
        @(negedge clk);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        model_read(a, cyc, exp, known);
        @(posedge clk);
        busy_n   = 0;
        ready_at = 0;
        for (int k = 1; k <= 12 && ready_at == 0; k++) begin
            @(negedge clk);
            if (bus.mem_busy)  busy_n++;
            if (bus.mem_ready) ready_at = k;
            if (k == 1) begin
                bus.mem_addr  = 16'($urandom);
                bus.mem_wdata = 16'($urandom);
            end
        end
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        check("ready_latency", ready_at, 2 + WS);
        check("busy_cycles", busy_n, WS + 1);
        if (wr) begin
            if (rd) m_err = 1'b1;
            if (a >= 16'hFF00) begin
                if (a == 16'hFF00) m_leds = d[7:0];
            end else begin
                mram[int'(a[11:0])] = d;
            end
            if (m_rdata_known) check("rdata_hold", bus.mem_rdata, m_rdata);
        end else if (known) begin
            check($sformatf("rdata@%h", a), bus.mem_rdata, exp);
            m_rdata       = exp;
            m_rdata_known = 1'b1;
        end else begin
            m_rdata_known = 1'b0;
        end
        check("leds", leds, m_leds);
    endtask

    initial begin
        int ready_seen;
        logic [15:0] a;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        model_reset();

        do_reset();
        check("rst_busy", bus.mem_busy, 1'b0);
        check("rst_ready", bus.mem_ready, 1'b0);
        check("rst_rdata", bus.mem_rdata, 16'h0000);
        check("rst_leds", leds, 8'h00);
        txn(1, 0, 16'hFF02, 16'h0000);
        check("rst_status", bus.mem_rdata, 16'h0001);

        txn(0, 1, 16'h0010, 16'hBEEF);
        txn(1, 0, 16'h0010, 16'h0000);
        check("ram_beef", bus.mem_rdata, 16'hBEEF);

        txn(0, 1, 16'hFF00, 16'h00A5);
        check("leds_a5", leds, 8'hA5);
        txn(1, 0, 16'hFF00, 16'h0000);
        check("led_read", bus.mem_rdata, 16'h00A5);
        txn(0, 1, 16'hFF01, 16'hFFFF);
        txn(1, 0, 16'hFF01, 16'h0000);
        txn(1, 0, 16'hFF07, 16'h0000);

        txn(0, 1, 16'h1005, 16'h1234);
        txn(1, 0, 16'h0005, 16'h0000);
        check("alias", bus.mem_rdata, 16'h1234);

        txn(1, 1, 16'h0020, 16'h5555);
        txn(1, 0, 16'h0020, 16'h0000);
        check("both_ram", bus.mem_rdata, 16'h5555);
        txn(1, 0, 16'hFF02, 16'h0000);
        check("err_status", bus.mem_rdata, 16'h0003);

        txn(0, 1, 16'h0030, 16'h1111);
        @(negedge clk);
        bus.mem_addr  = 16'h0030;
        bus.mem_wdata = 16'h2222;
        bus.mem_wr    = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        bus.mem_wr = 1'b0;
        ready_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst = 1'b0;
            if (bus.mem_ready) ready_seen++;
        end
        model_reset();
        check("abort_no_ready", ready_seen, 0);
        txn(1, 0, 16'h0030, 16'h0000);
        check("abort_no_write", bus.mem_rdata, 16'h1111);
        txn(1, 0, 16'hFF02, 16'h0000);
        check("abort_err_clr", bus.mem_rdata, 16'h0001);

        for (int i = 0; i < 60; i++) begin
            int pick, op;
            pick = int'($urandom_range(0, 9));
            op   = int'($urandom_range(0, 9));
            if (pick < 6) a = 16'($urandom_range(0, 7)) + 16'h1000 * 16'($urandom_range(0, 14));
            else if (pick < 9) a = 16'hFF00 + 16'($urandom_range(0, 3));
            else a = 16'hFFFF;
            if (op < 5)      txn(1, 0, a, 16'($urandom));
            else if (op < 9) txn(0, 1, a, 16'($urandom));
            else             txn(1, 1, a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
